// File: rtl/bnn_frame_seq.sv
// bnn_frame_seq: assembles a binary frame row by row for the BNN core, lets it settle, then argmaxes the class scores.
// Latency: last row accepted -> res_valid_o after SETTLE_CYCLES+NCLASS cycles.
// Backpressure: rows accepted only in LOAD; result held until res_ready_i; one frame in flight at a time.
module bnn_frame_seq #(
    parameter int ROWS          = 32,
    parameter int COLS          = 32,
    parameter int NCLASS        = 4,
    parameter int SCORE_W       = 7,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        row_valid_i,
    output logic                        row_ready_o,
    input  logic [COLS-1:0]             row_data_i,
    output logic [ROWS*COLS-1:0]        frame_o,
    input  logic [NCLASS*SCORE_W-1:0]   score_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [$clog2(NCLASS)-1:0]   res_class_o,
    output logic [SCORE_W-1:0]          res_score_o,
    output logic                        busy_o,
    output logic [15:0]                 frame_cnt_o
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLS_W = $clog2(NCLASS);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_ARGMAX,
        S_RESULT
    } state_t;

    typedef struct packed {
        logic [CLS_W-1:0]   cls;
        logic [SCORE_W-1:0] score;
    } best_t;

    state_t                 state;
    logic [ROW_W-1:0]       row_idx;
    logic [CNT_W-1:0]       settle_cnt;
    logic [CLS_W-1:0]       cmp_idx;
    logic [SCORE_W-1:0]     score_q [NCLASS];
    best_t                  best;
    best_t                  best_nxt;
    best_t                  res_q;
    logic                   res_valid_q;
    logic [ROWS*COLS-1:0]   frame_q;
    logic [15:0]            frame_cnt_q;
    logic [SCORE_W-1:0]     cand;
    logic                   row_acc;

    assign row_ready_o = (state == S_LOAD);
    assign row_acc     = row_valid_i && row_ready_o;

    // Strict compare keeps the earlier (lower) index on ties.
    always_comb begin
        cand     = score_q[cmp_idx];
        best_nxt = best;
        if (cand > best.score) begin
            best_nxt.cls   = cmp_idx;
            best_nxt.score = cand;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_LOAD;
            row_idx     <= '0;
            settle_cnt  <= '0;
            cmp_idx     <= '0;
            best        <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            frame_q     <= '0;
            frame_cnt_q <= '0;
            for (int k = 0; k < NCLASS; k++) begin
                score_q[k] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (row_acc) begin
                        frame_q[row_idx*COLS +: COLS] <= row_data_i;
                        if (row_idx == ROW_W'(ROWS - 1)) begin
                            row_idx    <= '0;
                            settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                            state      <= S_SETTLE;
                        end else begin
                            row_idx <= row_idx + ROW_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    for (int k = 0; k < NCLASS; k++) begin
                        score_q[k] <= score_i[k*SCORE_W +: SCORE_W];
                    end
                    best.cls   <= '0;
                    best.score <= score_i[SCORE_W-1:0];
                    cmp_idx    <= CLS_W'(1);
                    state      <= S_ARGMAX;
                end
                S_ARGMAX: begin
                    best <= best_nxt;
                    if (cmp_idx == CLS_W'(NCLASS - 1)) begin
                        res_q       <= best_nxt;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end else begin
                        cmp_idx <= cmp_idx + CLS_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state       <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign frame_o     = frame_q;
    assign res_valid_o = res_valid_q;
    assign res_class_o = res_q.cls;
    assign res_score_o = res_q.score;
    assign busy_o      = (state != S_LOAD);
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_bnn_frame_seq.sv
// Bench for bnn_frame_seq: randomized frames and scores against a plain argmax / frame-buffer model.
module tb_bnn_frame_seq;
    localparam int ROWS = 32, COLS = 32, NCLASS = 4, SCORE_W = 7, SETTLE = 16;
    localparam int SV_W = NCLASS * SCORE_W;
    localparam int LAT = SETTLE + NCLASS;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   row_valid_i;
    logic                   row_ready_o;
    logic [COLS-1:0]        row_data_i;
    logic [ROWS*COLS-1:0]   frame_o;
    logic [SV_W-1:0]        score_i;
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [1:0]             res_class_o;
    logic [SCORE_W-1:0]     res_score_o;
    logic                   busy_o;
    logic [15:0]            frame_cnt_o;

    bnn_frame_seq #(
        .ROWS(ROWS), .COLS(COLS), .NCLASS(NCLASS), .SCORE_W(SCORE_W), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_data_i(row_data_i),
        .frame_o(frame_o), .score_i(score_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_class_o(res_class_o), .res_score_o(res_score_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic [ROWS*COLS-1:0] exp_frame;
    logic [15:0]          exp_cnt;
    int                   checks = 0;
    int                   passes = 0;

    function automatic logic [SV_W-1:0] pack_scores(input int s0, input int s1, input int s2, input int s3);
        return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
    endfunction

    // Reference argmax: first maximum wins.
    function automatic void ref_argmax(input logic [SV_W-1:0] sv, output int cls, output int sc);
        logic [SCORE_W-1:0] v;
        cls = 0;
        sc  = -1;
        for (int k = 0; k < NCLASS; k++) begin
            v = sv[k*SCORE_W +: SCORE_W];
            if (int'(v) > sc) begin
                sc  = int'(v);
                cls = k;
            end
        end
    endfunction

    // All driver tasks start and end just after a falling edge.
    task automatic push_row(input logic [COLS-1:0] d, output bit ok);
        ok = 0;
        row_valid_i = 1'b1;
        row_data_i  = d;
        for (int n = 0; n < 64; n++) begin
            if (row_ready_o) begin
                @(negedge clk_i);
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        row_valid_i = 1'b0;
    endtask

    task automatic push_frame(input logic [COLS-1:0] rows [ROWS], output bit ok);
        bit rok;
        ok = 1;
        for (int r = 0; r < ROWS; r++) begin
            push_row(rows[r], rok);
            if (!rok) begin
                ok = 0;
                break;
            end
            exp_frame[r*COLS +: COLS] = rows[r];
        end
    endtask

    // Noisy mode keeps offering rows and scrambles score_i except for the cycle it is captured.
    task automatic wait_result(input logic [SV_W-1:0] sv, input bit noisy, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (noisy) begin
                row_valid_i = 1'b1;
                row_data_i  = $urandom;
                score_i     = (k == SETTLE + 1) ? sv : SV_W'($urandom);
            end
            @(negedge clk_i);
            if (res_valid_o) begin
                lat = k;
                break;
            end
        end
        row_valid_i = 1'b0;
    endtask

    task automatic random_rows(output logic [COLS-1:0] rows [ROWS]);
        for (int r = 0; r < ROWS; r++) rows[r] = $urandom;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row_valid_i = 1'($urandom_range(0, 1));
            row_data_i  = $urandom;
            score_i     = SV_W'($urandom);
            res_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
        end
        exp_frame = '0;
        exp_cnt   = '0;
        checks++; if (frame_o !== exp_frame) $display("FAIL reset_frame got %h exp 0", frame_o); else passes++;
        checks++; if (res_valid_o !== 1'b0) $display("FAIL reset_res_valid got %b exp 0", res_valid_o); else passes++;
        checks++; if (res_class_o !== 2'd0 || res_score_o !== 7'd0)
            $display("FAIL reset_result got %0d/%0d exp 0/0", res_class_o, res_score_o); else passes++;
        checks++; if (busy_o !== 1'b0 || frame_cnt_o !== 16'd0)
            $display("FAIL reset_busy_cnt got %b/%0d exp 0/0", busy_o, frame_cnt_o); else passes++;
        row_valid_i = 1'b0;
        res_ready_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (row_ready_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL reset_release got ready=%b busy=%b exp 1/0", row_ready_o, busy_o); else passes++;
    endtask

    task automatic test_nominal();
        logic [COLS-1:0]      rows [ROWS];
        logic [ROWS*COLS-1:0] diag;
        logic [SV_W-1:0]      sv;
        bit ok;
        int lat;
        diag = '0;
        for (int r = 0; r < ROWS; r++) begin
            rows[r] = 32'd1 << r;
            diag[r*COLS + r] = 1'b1;
        end
        sv = pack_scores(10, 50, 30, 20);
        score_i = sv;
        push_frame(rows, ok);
        checks++; if (!ok || frame_o !== diag) $display("FAIL nominal_frame ok=%b got %h exp %h", ok, frame_o, diag); else passes++;
        wait_result(sv, 1'b0, lat);
        checks++; if (lat !== LAT) $display("FAIL nominal_latency got %0d exp %0d", lat, LAT); else passes++;
        checks++; if (res_class_o !== 2'd1 || res_score_o !== 7'd50)
            $display("FAIL nominal_result got %0d/%0d exp 1/50", res_class_o, res_score_o); else passes++;
        checks++; if (busy_o !== 1'b1 || row_ready_o !== 1'b0)
            $display("FAIL nominal_busy got busy=%b ready=%b exp 1/0", busy_o, row_ready_o); else passes++;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        exp_cnt++;
        checks++; if (res_valid_o !== 1'b0 || frame_cnt_o !== exp_cnt)
            $display("FAIL nominal_handshake got valid=%b cnt=%0d exp 0/%0d", res_valid_o, frame_cnt_o, exp_cnt); else passes++;
        checks++; if (row_ready_o !== 1'b1 || res_class_o !== 2'd1 || res_score_o !== 7'd50)
            $display("FAIL nominal_hold got ready=%b %0d/%0d exp 1 1/50", row_ready_o, res_class_o, res_score_o); else passes++;
    endtask

    task automatic test_ties();
        logic [COLS-1:0] rows [ROWS];
        logic [SV_W-1:0] tbl [3];
        int exp_c [3];
        int exp_s [3];
        bit ok;
        int lat;
        tbl[0] = pack_scores(40, 40, 40, 40);  exp_c[0] = 0; exp_s[0] = 40;
        tbl[1] = pack_scores(0, 0, 0, 127);    exp_c[1] = 3; exp_s[1] = 127;
        tbl[2] = pack_scores(0, 0, 0, 0);      exp_c[2] = 0; exp_s[2] = 0;
        for (int t = 0; t < 3; t++) begin
            random_rows(rows);
            score_i = tbl[t];
            push_frame(rows, ok);
            wait_result(tbl[t], 1'b0, lat);
            checks++; if (!ok || lat !== LAT || int'(res_class_o) != exp_c[t] || int'(res_score_o) != exp_s[t])
                $display("FAIL ties_%0d ok=%b lat=%0d got %0d/%0d exp %0d/%0d", t, ok, lat,
                         res_class_o, res_score_o, exp_c[t], exp_s[t]); else passes++;
            res_ready_i = 1'b1;
            @(negedge clk_i);
            res_ready_i = 1'b0;
            exp_cnt++;
            checks++; if (frame_cnt_o !== exp_cnt) $display("FAIL ties_cnt_%0d got %0d exp %0d", t, frame_cnt_o, exp_cnt); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [COLS-1:0] rows [ROWS];
        logic [SV_W-1:0] sv;
        bit ok;
        int lat, ec, es;
        random_rows(rows);
        sv = pack_scores(5, 90, 91, 12);
        ref_argmax(sv, ec, es);
        score_i = sv;
        push_frame(rows, ok);
        wait_result(sv, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            score_i = SV_W'($urandom);
            @(negedge clk_i);
            checks++; if (res_valid_o !== 1'b1 || int'(res_class_o) != ec || int'(res_score_o) != es || row_ready_o !== 1'b0)
                $display("FAIL bp_hold_%0d got v=%b %0d/%0d rdy=%b exp 1 %0d/%0d 0", i, res_valid_o,
                         res_class_o, res_score_o, row_ready_o, ec, es); else passes++;
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        exp_cnt++;
        checks++; if (res_valid_o !== 1'b0 || row_ready_o !== 1'b1 || frame_cnt_o !== exp_cnt)
            $display("FAIL bp_release got v=%b rdy=%b cnt=%0d exp 0/1/%0d", res_valid_o, row_ready_o, frame_cnt_o, exp_cnt); else passes++;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (frame_cnt_o !== exp_cnt || res_valid_o !== 1'b0)
            $display("FAIL bp_single got cnt=%0d v=%b exp %0d/0", frame_cnt_o, res_valid_o, exp_cnt); else passes++;
    endtask

    task automatic test_flow_control();
        logic [COLS-1:0] rows [ROWS];
        logic [SV_W-1:0] sv;
        bit ok;
        int lat, ec, es;
        random_rows(rows);
        sv = pack_scores(33, 7, 33, 100);
        ref_argmax(sv, ec, es);
        score_i = sv;
        push_frame(rows, ok);
        wait_result(sv, 1'b1, lat);
        checks++; if (!ok || frame_o !== exp_frame) $display("FAIL flow_frame ok=%b got %h exp %h", ok, frame_o, exp_frame); else passes++;
        checks++; if (lat !== LAT || int'(res_class_o) != ec || int'(res_score_o) != es)
            $display("FAIL flow_result lat=%0d got %0d/%0d exp %0d %0d/%0d", lat, res_class_o, res_score_o, LAT, ec, es); else passes++;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_midframe_reset();
        logic [COLS-1:0] rows [ROWS];
        logic [SV_W-1:0] sv;
        bit ok;
        int lat, ec, es;
        for (int r = 0; r < 10; r++) push_row(32'hFFFF_FFFF, ok);
        #2 rst_ni = 1'b0;
        #1;
        exp_frame = '0;
        exp_cnt   = '0;
        checks++; if (frame_o !== exp_frame || frame_cnt_o !== 16'd0 || busy_o !== 1'b0)
            $display("FAIL midreset_clear got frame=%h cnt=%0d busy=%b exp 0/0/0", frame_o, frame_cnt_o, busy_o); else passes++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        random_rows(rows);
        sv = pack_scores($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
        ref_argmax(sv, ec, es);
        score_i = sv;
        push_frame(rows, ok);
        checks++; if (!ok || frame_o !== exp_frame) $display("FAIL midreset_frame ok=%b got %h exp %h", ok, frame_o, exp_frame); else passes++;
        wait_result(sv, 1'b0, lat);
        checks++; if (lat !== LAT || int'(res_class_o) != ec || int'(res_score_o) != es)
            $display("FAIL midreset_result lat=%0d got %0d/%0d exp %0d %0d/%0d", lat, res_class_o, res_score_o, LAT, ec, es); else passes++;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        exp_cnt++;
        checks++; if (frame_cnt_o !== exp_cnt) $display("FAIL midreset_cnt got %0d exp %0d", frame_cnt_o, exp_cnt); else passes++;
    endtask

    task automatic test_random();
        logic [COLS-1:0] rows [ROWS];
        logic [SV_W-1:0] sv;
        bit ok, noisy;
        int lat, ec, es, hi, bp;
        for (int f = 0; f < 8; f++) begin
            random_rows(rows);
            hi = ($urandom_range(0, 1) == 1) ? 127 : 3;
            sv = pack_scores($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
            ref_argmax(sv, ec, es);
            noisy = 1'($urandom_range(0, 1));
            score_i = sv;
            push_frame(rows, ok);
            wait_result(sv, noisy, lat);
            checks++; if (!ok || frame_o !== exp_frame) $display("FAIL rand_frame_%0d ok=%b got %h exp %h", f, ok, frame_o, exp_frame); else passes++;
            checks++; if (lat !== LAT || int'(res_class_o) != ec || int'(res_score_o) != es)
                $display("FAIL rand_result_%0d lat=%0d got %0d/%0d exp %0d %0d/%0d", f, lat, res_class_o, res_score_o, LAT, ec, es); else passes++;
            bp = $urandom_range(0, 3);
            repeat (bp) @(negedge clk_i);
            res_ready_i = 1'b1;
            @(negedge clk_i);
            res_ready_i = 1'b0;
            exp_cnt++;
            checks++; if (frame_cnt_o !== exp_cnt || res_valid_o !== 1'b0)
                $display("FAIL rand_cnt_%0d got %0d v=%b exp %0d/0", f, frame_cnt_o, res_valid_o, exp_cnt); else passes++;
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        row_valid_i = 1'b0;
        row_data_i  = '0;
        score_i     = '0;
        res_ready_i = 1'b0;
        exp_frame   = '0;
        exp_cnt     = '0;
        @(negedge clk_i);
        test_reset();
        test_nominal();
        test_ties();
        test_backpressure();
        test_flow_control();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
